// File: rtl/alu_pkg.sv
// Shared ALU definitions: op code constants and the arbiter FSM state encoding.
package alu_pkg;

    localparam logic [4:0] ALU_OP_ADD  = 5'd0;
    localparam logic [4:0] ALU_OP_ADDU = 5'd1;
    localparam logic [4:0] ALU_OP_SUB  = 5'd2;
    localparam logic [4:0] ALU_OP_SUBU = 5'd3;
    localparam logic [4:0] ALU_OP_AND  = 5'd4;
    localparam logic [4:0] ALU_OP_OR   = 5'd5;
    localparam logic [4:0] ALU_OP_NOR  = 5'd6;
    localparam logic [4:0] ALU_OP_SLT  = 5'd7;
    localparam logic [4:0] ALU_OP_SLL  = 5'd8;
    localparam logic [4:0] ALU_OP_SRL  = 5'd9;
    localparam logic [4:0] ALU_OP_SRA  = 5'd10;
    localparam logic [4:0] ALU_OP_JR   = 5'd11;
    localparam logic [4:0] ALU_OP_NOP  = 5'd12;
    localparam logic [4:0] ALU_OP_MAX  = 5'd12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/alu_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr, wrapping.
module alu_rr_pick
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDW     = 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDW-1:0]     rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     winner,
    output logic               any_valid
);

    int idx;

    // Scan from the farthest candidate back to rr_ptr so the nearest valid one is written last.
    always_comb begin
        grant     = '0;
        winner    = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (valid[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                winner     = IDW'(idx);
                any_valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among NUM_REQ requesters, one operation in flight.
// Optional ALU_ARB_OPCHECK_EN: op codes above 12 are not issued and are answered with rsp_err=1.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDW     = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*5-1:0] req_op_code,
    input  logic [NUM_REQ*32-1:0] req_reg1,
    input  logic [NUM_REQ*32-1:0] req_reg2,
    input  logic [NUM_REQ*5-1:0] req_shamt,
    output logic [31:0]          alu_reg1,
    output logic [31:0]          alu_reg2,
    output logic [4:0]           alu_op_code,
    output logic [4:0]           alu_shamt,
    input  logic [31:0]          alu_result,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_result,
    output logic                 rsp_err
);

    arb_state_e           state_q, state_d;
    logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [31:0]          alu_reg1_q, alu_reg1_d;
    logic [31:0]          alu_reg2_q, alu_reg2_d;
    logic [4:0]           alu_op_code_q, alu_op_code_d;
    logic [4:0]           alu_shamt_q, alu_shamt_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]       rsp_id_q, rsp_id_d;
    logic [31:0]          rsp_result_q, rsp_result_d;
    logic                 rsp_err_q, rsp_err_d;

    logic [NUM_REQ-1:0]   grant;
    logic [IDW-1:0]       winner;
    logic                 any_valid;
    logic [4:0]           win_op;
    logic [31:0]          win_reg1;
    logic [31:0]          win_reg2;
    logic [4:0]           win_shamt;
    logic                 win_illegal;

    alu_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .valid     (req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant),
        .winner    (winner),
        .any_valid (any_valid)
    );

    assign req_ready = (state_q == ST_IDLE) ? grant : '0;

    assign win_op    = req_op_code[int'(winner) * 5 +: 5];
    assign win_reg1  = req_reg1[int'(winner) * 32 +: 32];
    assign win_reg2  = req_reg2[int'(winner) * 32 +: 32];
    assign win_shamt = req_shamt[int'(winner) * 5 +: 5];

`ifdef ALU_ARB_OPCHECK_EN
    assign win_illegal = (win_op > ALU_OP_MAX);
`else
    assign win_illegal = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        alu_reg1_d    = alu_reg1_q;
        alu_reg2_d    = alu_reg2_q;
        alu_op_code_d = alu_op_code_q;
        alu_shamt_d   = alu_shamt_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_id_d      = rsp_id_q;
        rsp_result_d  = rsp_result_q;
        rsp_err_d     = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (any_valid) begin
                    alu_reg1_d    = win_reg1;
                    alu_reg2_d    = win_reg2;
                    alu_shamt_d   = win_shamt;
                    alu_op_code_d = win_illegal ? ALU_OP_NOP : win_op;
                    rsp_id_d      = winner;
                    rsp_err_d     = win_illegal;
                    rr_ptr_d      = (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                    state_d       = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // A rejected op never reached the ALU, so its result is forced to zero.
                rsp_result_d = rsp_err_q ? '0 : alu_result;
                rsp_valid_d  = 1'b1;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d   = 1'b0;
                    alu_op_code_d = ALU_OP_NOP;
                    state_d       = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= '0;
            alu_reg1_q    <= '0;
            alu_reg2_q    <= '0;
            alu_op_code_q <= ALU_OP_NOP;
            alu_shamt_q   <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_result_q  <= '0;
            rsp_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            alu_reg1_q    <= alu_reg1_d;
            alu_reg2_q    <= alu_reg2_d;
            alu_op_code_q <= alu_op_code_d;
            alu_shamt_q   <= alu_shamt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_result_q  <= rsp_result_d;
            rsp_err_q     <= rsp_err_d;
        end
    end

    assign alu_reg1    = alu_reg1_q;
    assign alu_reg2    = alu_reg2_q;
    assign alu_op_code = alu_op_code_q;
    assign alu_shamt   = alu_shamt_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_err     = rsp_err_q;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single combinational ALU (op codes 0-12: add, addu, sub, subu, and, or, nor, slt, sll, srl, sra, jr, nop) between NUM_REQ requesters. Each requester has a valid/ready request channel and receives results on a common tagged response channel. The block sits between the issue logic of the requesters and the ALU, and registers the ALU operands and the result. Arbitration is round-robin, with one operation in flight at a time.

Parameters:
NUM_REQ, 2, number of requesters; legal range 2..8.
IDW, 1, requester ID width; must equal ceil(log2(NUM_REQ)).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester accept (combinational, one-hot or zero)
req_op_code  input  NUM_REQ*5  flattened op codes; requester i occupies [5i+4:5i]
req_reg1  input  NUM_REQ*32  flattened operand 1
req_reg2  input  NUM_REQ*32  flattened operand 2
req_shamt  input  NUM_REQ*5  flattened shift amounts
alu_reg1  output  32  registered operand to ALU
alu_reg2  output  32  registered operand to ALU
alu_op_code  output  5  registered op code to ALU
alu_shamt  output  5  registered shamt to ALU
alu_result  input  32  ALU result
rsp_valid  output  1  response valid
rsp_ready  input  1  response accept
rsp_id  output  IDW  requester index that owns the response
rsp_result  output  32  captured ALU result
rsp_err  output  1  illegal op code flag (see Optional Feature)

Behaviour:
- One clock, clk. Reset is synchronous and active-low (rst_n sampled on the rising edge of clk).
- Reset values:
  - state = IDLE; rr_ptr = 0.
  - rsp_valid = 0, rsp_id = 0, rsp_result = 0, rsp_err = 0.
  - alu_reg1 = 0, alu_reg2 = 0, alu_shamt = 0, alu_op_code = 12 (nop).
- FSM: IDLE -> ISSUE -> RESP -> IDLE.
- IDLE:
  - Winner = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready[winner] = 1; all other req_ready bits = 0. If no req_valid, req_ready = 0.
  - On acceptance (cycle T): latch the winner's operands into alu_*, latch the winner into rsp_id, set rr_ptr = winner+1 (wrapping NUM_REQ-1 -> 0), go to ISSUE.
- ISSUE (T+1): alu_* hold the latched request. At the end of the cycle, capture alu_result into rsp_result and go to RESP.
- RESP (T+2 onward):
  - rsp_valid = 1. rsp_id, rsp_result and rsp_err stay stable until rsp_ready = 1.
  - On the rsp_valid & rsp_ready edge: rsp_valid clears, alu_op_code returns to 12 (operands hold), go to IDLE.
- req_ready is 0 in ISSUE and RESP. Minimum occupancy is 3 cycles per operation; request-to-response latency is 2 cycles.
- Requesters hold req_valid and operands stable until accepted. Dropping req_valid before acceptance is legal; that request is simply not served.
- rr_ptr advances only on acceptance, so a requester asserting continuously is never starved beyond NUM_REQ-1 grants to others.
- Operand and result widths are passed through unchanged; the block performs no arithmetic.
- rsp_ready asserted while rsp_valid = 0 is ignored.
- rst_n low in any state: the in-flight operation and its response are discarded, and the reset values apply on the next edge.

Optional Feature:
- Macro: ALU_ARB_OPCHECK_EN.
- Defined:
  - An accepted op code greater than 12 is not issued; alu_op_code stays 12.
  - The FSM still passes through ISSUE and RESP with rsp_result = 0 and rsp_err = 1.
  - Legal ops give rsp_err = 0.
- Undefined:
  - Every op code is passed to the ALU unmodified and rsp_err is tied 0.
  - An illegal op returns whatever alu_result holds.

Decomposition:
- Shared package alu_pkg:
  - op code constants ALU_OP_ADD=0, ALU_OP_ADDU=1, ALU_OP_SUB=2, ALU_OP_SUBU=3, ALU_OP_AND=4, ALU_OP_OR=5, ALU_OP_NOR=6, ALU_OP_SLT=7, ALU_OP_SLL=8, ALU_OP_SRL=9, ALU_OP_SRA=10, ALU_OP_JR=11, ALU_OP_NOP=12, ALU_OP_MAX=12;
  - FSM state encoding (IDLE, ISSUE, RESP).
- One sub-module, alu_rr_pick: combinational round-robin picker. Inputs are the valid vector and rr_ptr; outputs are the one-hot grant, the winner index and an any-valid flag.
- The FSM, registers and muxing stay in alu_arbiter.

Test Plan:
- Single request: requester 0 issues op 0 with reg1=5, reg2=7; rsp_ready=1. Expect req_ready[0] high at T, rsp_valid at T+2, rsp_id=0, rsp_result=12, then return to IDLE.
- Contention: both requesters continuously valid (op 2 with 10,3 and op 4 with 0xF0,0x3C). Expect grants 0,1,0,1. Results alternate 7 and 0x30 with matching rsp_id, one response every 3 cycles.
- Backpressure: hold rsp_ready=0 for 5 cycles during RESP. Expect rsp_valid, rsp_id and rsp_result stable, all req_ready=0, and no new accept until the handshake.
- Shift via ALU: op 10, reg1=0x80000000, shamt=4. Expect rsp_result=0xF8000000. Then op 7 with reg1=3, reg2=9 gives 1.
- Reset mid-operation: drive rst_n=0 in ISSUE. Expect the next cycle to show rsp_valid=0, alu_op_code=12, rr_ptr=0, and no response for the dropped request.
- ALU_ARB_OPCHECK_EN defined: op 20. Expect alu_op_code to stay 12, rsp_err=1 and rsp_result=0. Without the macro, expect rsp_err=0.
